// File: rtl/csr_exc_unit.sv
// LA32 privileged CSR subset, stable timer and interrupt detection, with
// the exception-entry / ertn controller that issues the pipeline flush.
module csr_exc_unit #(
  parameter int TIMER_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        csr_we,
  input  logic [13:0] csr_num,
  input  logic [31:0] csr_wmask,
  input  logic [31:0] csr_wdata,
  input  logic [13:0] csr_rnum,
  output logic [31:0] csr_rvalue,
  input  logic        wb_ertn,
  input  logic        wb_syscall,
  input  logic [14:0] wb_syscall_code,
  output logic        has_int,
  output logic        wb_cancel,
  output logic        flush,
  output logic [31:0] flush_target
);

  localparam logic [13:0] CSR_CRMD   = 14'h0;
  localparam logic [13:0] CSR_PRMD   = 14'h1;
  localparam logic [13:0] CSR_ECFG   = 14'h4;
  localparam logic [13:0] CSR_ESTAT  = 14'h5;
  localparam logic [13:0] CSR_ERA    = 14'h6;
  localparam logic [13:0] CSR_EENTRY = 14'hC;
  localparam logic [13:0] CSR_SAVE0  = 14'h30;
  localparam logic [13:0] CSR_SAVE1  = 14'h31;
  localparam logic [13:0] CSR_SAVE2  = 14'h32;
  localparam logic [13:0] CSR_SAVE3  = 14'h33;
  localparam logic [13:0] CSR_TID    = 14'h40;
  localparam logic [13:0] CSR_TCFG   = 14'h41;
  localparam logic [13:0] CSR_TVAL   = 14'h42;
  localparam logic [13:0] CSR_TICLR  = 14'h44;

  logic [1:0]         crmd_plv;
  logic               crmd_ie, crmd_da, crmd_pg;
  logic [1:0]         prmd_pplv;
  logic               prmd_pie;
  logic [12:0]        ecfg_lie;
  logic [1:0]         is_sw;
  logic               is_timer;
  logic [5:0]         ecode;
  logic [8:0]         esubcode;
  logic [31:0]        era;
  logic [25:0]        eentry_va;
  logic [31:0]        save0, save1, save2, save3, tid;
  logic               tcfg_en, tcfg_periodic;
  logic [29:0]        tcfg_initval;
  logic [TIMER_W-1:0] tval;
  logic               reset_q;

  logic [12:0] estat_is;
  logic [31:0] crmd_v, prmd_v, ecfg_v, estat_v, eentry_v, tcfg_v;
  logic [31:0] wval;
  logic        blocked, int_evt, sys_evt, ertn_evt, exc_evt, eff_we, timer_fire;

  function automatic logic [31:0] wmerge(input logic [31:0] old_v,
                                         input logic [31:0] mask,
                                         input logic [31:0] data);
    return (old_v & ~mask) | (data & mask);
  endfunction

  logic unused_syscall_code;
  assign unused_syscall_code = ^wb_syscall_code;

  assign estat_is = {1'b0, is_timer, 9'b0, is_sw};
  assign crmd_v   = {27'b0, crmd_pg, crmd_da, crmd_ie, crmd_plv};
  assign prmd_v   = {29'b0, prmd_pie, prmd_pplv};
  assign ecfg_v   = {19'b0, ecfg_lie};
  assign estat_v  = {1'b0, esubcode, ecode, 3'b0, estat_is};
  assign eentry_v = {eentry_va, 6'b0};
  assign tcfg_v   = {tcfg_initval, tcfg_periodic, tcfg_en};

  // Outputs are held quiet during reset and the cycle that follows it.
  assign blocked  = reset | reset_q;
  assign has_int  = ~blocked & crmd_ie & (|(estat_is & ecfg_lie));
  assign int_evt  = wb_valid & has_int;
  assign sys_evt  = wb_valid & ~blocked & ~has_int & wb_syscall;
  assign ertn_evt = wb_valid & ~blocked & ~has_int & ~wb_syscall & wb_ertn;
  assign exc_evt  = int_evt | sys_evt;

  assign wb_cancel    = int_evt;
  assign flush        = exc_evt | ertn_evt;
  assign flush_target = ertn_evt ? era : eentry_v;

  // Any event takes the CSR port, so a same-cycle write never lands.
  assign eff_we     = wb_valid & csr_we & ~wb_cancel & ~sys_evt & ~ertn_evt;
  assign timer_fire = tcfg_en & (tval == '0);

  always_comb begin
    wval = '0;
    case (csr_num)
      CSR_CRMD:   wval = wmerge(crmd_v,   csr_wmask, csr_wdata);
      CSR_PRMD:   wval = wmerge(prmd_v,   csr_wmask, csr_wdata);
      CSR_ECFG:   wval = wmerge(ecfg_v,   csr_wmask, csr_wdata);
      CSR_ESTAT:  wval = wmerge(estat_v,  csr_wmask, csr_wdata);
      CSR_ERA:    wval = wmerge(era,      csr_wmask, csr_wdata);
      CSR_EENTRY: wval = wmerge(eentry_v, csr_wmask, csr_wdata);
      CSR_SAVE0:  wval = wmerge(save0,    csr_wmask, csr_wdata);
      CSR_SAVE1:  wval = wmerge(save1,    csr_wmask, csr_wdata);
      CSR_SAVE2:  wval = wmerge(save2,    csr_wmask, csr_wdata);
      CSR_SAVE3:  wval = wmerge(save3,    csr_wmask, csr_wdata);
      CSR_TID:    wval = wmerge(tid,      csr_wmask, csr_wdata);
      CSR_TCFG:   wval = wmerge(tcfg_v,   csr_wmask, csr_wdata);
      CSR_TICLR:  wval = wmerge(32'h0,    csr_wmask, csr_wdata);
      default:    wval = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    reset_q <= reset;
    if (reset) begin
      crmd_plv <= '0; crmd_ie <= 1'b0; crmd_da <= 1'b1; crmd_pg <= 1'b0;
      prmd_pplv <= '0; prmd_pie <= 1'b0;
      ecfg_lie <= '0; is_sw <= '0; ecode <= '0; esubcode <= '0;
      era <= '0; eentry_va <= '0;
      save0 <= '0; save1 <= '0; save2 <= '0; save3 <= '0; tid <= '0;
      tcfg_en <= 1'b0; tcfg_periodic <= 1'b0; tcfg_initval <= '0;
    end else if (exc_evt) begin
      prmd_pplv <= crmd_plv;
      prmd_pie  <= crmd_ie;
      crmd_plv  <= '0;
      crmd_ie   <= 1'b0;
      era       <= wb_pc;
      ecode     <= int_evt ? 6'h0 : 6'hB;
      esubcode  <= '0;
    end else if (ertn_evt) begin
      crmd_plv <= prmd_pplv;
      crmd_ie  <= prmd_pie;
    end else if (eff_we) begin
      case (csr_num)
        CSR_CRMD:   {crmd_pg, crmd_da, crmd_ie, crmd_plv} <= wval[4:0];
        CSR_PRMD:   {prmd_pie, prmd_pplv} <= wval[2:0];
        CSR_ECFG:   ecfg_lie <= wval[12:0] & 13'h1BFF;
        CSR_ESTAT:  is_sw <= wval[1:0];
        CSR_ERA:    era <= wval;
        CSR_EENTRY: eentry_va <= wval[31:6];
        CSR_SAVE0:  save0 <= wval;
        CSR_SAVE1:  save1 <= wval;
        CSR_SAVE2:  save2 <= wval;
        CSR_SAVE3:  save3 <= wval;
        CSR_TID:    tid <= wval;
        CSR_TCFG:   {tcfg_initval, tcfg_periodic, tcfg_en} <= wval;
        default:    ;
      endcase
    end
  end

  // Timer: a TCFG write with En=1 reloads; otherwise count down to 0,
  // fire, then reload (periodic) or park at all-ones (one-shot).
  always_ff @(posedge clk) begin
    if (reset) begin
      tval     <= '1;
      is_timer <= 1'b0;
    end else begin
      if (eff_we && csr_num == CSR_TCFG && wval[0])
        tval <= TIMER_W'({wval[31:2], 2'b00});
      else if (timer_fire)
        tval <= tcfg_periodic ? TIMER_W'({tcfg_initval, 2'b00}) : '1;
      else if (tcfg_en && tval != '1)
        tval <= tval - 1'b1;

      if (timer_fire)
        is_timer <= 1'b1;
      else if (eff_we && csr_num == CSR_TICLR && wval[0])
        is_timer <= 1'b0;
    end
  end

  always_comb begin
    csr_rvalue = '0;
    case (csr_rnum)
      CSR_CRMD:   csr_rvalue = crmd_v;
      CSR_PRMD:   csr_rvalue = prmd_v;
      CSR_ECFG:   csr_rvalue = ecfg_v;
      CSR_ESTAT:  csr_rvalue = estat_v;
      CSR_ERA:    csr_rvalue = era;
      CSR_EENTRY: csr_rvalue = eentry_v;
      CSR_SAVE0:  csr_rvalue = save0;
      CSR_SAVE1:  csr_rvalue = save1;
      CSR_SAVE2:  csr_rvalue = save2;
      CSR_SAVE3:  csr_rvalue = save3;
      CSR_TID:    csr_rvalue = tid;
      CSR_TCFG:   csr_rvalue = tcfg_v;
      CSR_TVAL:   csr_rvalue = 32'(tval);
      default:    csr_rvalue = '0;
    endcase
  end

endmodule

// File: tb/tb_csr_exc_unit.sv
// Bench for csr_exc_unit: write-vector table, scoreboard of CSR read-backs,
// and hand sequences for syscall/ertn, timer and interrupt corners.
module tb_csr_exc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [31:0] wb_pc;
  logic        csr_we;
  logic [13:0] csr_num;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wdata;
  logic [13:0] csr_rnum;
  logic [31:0] csr_rvalue;
  logic        wb_ertn;
  logic        wb_syscall;
  logic [14:0] wb_syscall_code;
  logic        has_int;
  logic        wb_cancel;
  logic        flush;
  logic [31:0] flush_target;

  csr_exc_unit #(.TIMER_W(32)) dut (
    .clk(clk), .reset(reset), .wb_valid(wb_valid), .wb_pc(wb_pc),
    .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask),
    .csr_wdata(csr_wdata), .csr_rnum(csr_rnum), .csr_rvalue(csr_rvalue),
    .wb_ertn(wb_ertn), .wb_syscall(wb_syscall),
    .wb_syscall_code(wb_syscall_code), .has_int(has_int),
    .wb_cancel(wb_cancel), .flush(flush), .flush_target(flush_target)
  );

  always #50 clk = ~clk;

  typedef struct {
    logic [13:0] num;
    logic [31:0] mask;
    logic [31:0] wdata;
    logic [31:0] old_v;
    logic [31:0] new_v;
  } wvec_t;

  typedef struct {
    logic [13:0] rnum;
    logic [31:0] exp_v;
    string       name;
  } sb_t;

  wvec_t wtab[16];
  sb_t   rtab[14];
  sb_t   sbq[$];
  int    tests = 0;
  int    failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic push(input logic [13:0] rnum, input logic [31:0] exp_v, input string name);
    sb_t e;
    e.rnum = rnum; e.exp_v = exp_v; e.name = name;
    sbq.push_back(e);
  endtask

  task automatic drain();
    sb_t e;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      csr_rnum = e.rnum;
      #1;
      chk(e.name, csr_rvalue, e.exp_v);
    end
  endtask

  task automatic idle();
    wb_valid = 0; wb_pc = '0; csr_we = 0; csr_num = '0; csr_wmask = '0;
    csr_wdata = '0; wb_ertn = 0; wb_syscall = 0; wb_syscall_code = '0;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
    idle();
    drain();
  endtask

  task automatic drive_wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] data);
    wb_valid = 1; csr_we = 1; csr_num = num; csr_wmask = mask; csr_wdata = data;
    csr_rnum = num;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    wtab[0]  = '{14'h30, 32'hFFFF_FFFF, 32'hFFFF_0000, 32'h0,         32'hFFFF_0000};
    wtab[1]  = '{14'h30, 32'h0000_FFFF, 32'h1234_5678, 32'hFFFF_0000, 32'hFFFF_5678};
    wtab[2]  = '{14'h04, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h0000_1BFF};
    wtab[3]  = '{14'h04, 32'hFFFF_FFFF, 32'h0,         32'h0000_1BFF, 32'h0};
    wtab[4]  = '{14'h05, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h0000_0003};
    wtab[5]  = '{14'h05, 32'hFFFF_FFFF, 32'h0,         32'h0000_0003, 32'h0};
    wtab[6]  = '{14'h0C, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFC0};
    wtab[7]  = '{14'h0C, 32'hFFFF_FFFF, 32'h1C00_8000, 32'hFFFF_FFC0, 32'h1C00_8000};
    wtab[8]  = '{14'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h0000_0007};
    wtab[9]  = '{14'h01, 32'hFFFF_FFFF, 32'h0,         32'h0000_0007, 32'h0};
    wtab[10] = '{14'h40, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h0,         32'hDEAD_BEEF};
    wtab[11] = '{14'h33, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0,         32'hF0F0_F0F0};
    wtab[12] = '{14'h07, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h0};
    wtab[13] = '{14'h42, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF, 32'hFFFF_FFFF};
    wtab[14] = '{14'h44, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'h0};
    wtab[15] = '{14'h00, 32'h0000_0007, 32'h0000_0007, 32'h0000_0008, 32'h0000_000F};

    rtab[0]  = '{14'h00, 32'h8, "rst_crmd"};
    rtab[1]  = '{14'h01, 32'h0, "rst_prmd"};
    rtab[2]  = '{14'h04, 32'h0, "rst_ecfg"};
    rtab[3]  = '{14'h05, 32'h0, "rst_estat"};
    rtab[4]  = '{14'h06, 32'h0, "rst_era"};
    rtab[5]  = '{14'h0C, 32'h0, "rst_eentry"};
    rtab[6]  = '{14'h30, 32'h0, "rst_save0"};
    rtab[7]  = '{14'h31, 32'h0, "rst_save1"};
    rtab[8]  = '{14'h32, 32'h0, "rst_save2"};
    rtab[9]  = '{14'h33, 32'h0, "rst_save3"};
    rtab[10] = '{14'h40, 32'h0, "rst_tid"};
    rtab[11] = '{14'h41, 32'h0, "rst_tcfg"};
    rtab[12] = '{14'h42, 32'hFFFF_FFFF, "rst_tval"};
    rtab[13] = '{14'h44, 32'h0, "rst_ticlr"};

    // Reset with a syscall presented: outputs must stay quiet.
    reset = 1; idle(); csr_rnum = '0;
    wb_valid = 1; wb_syscall = 1; wb_pc = 32'h1C00_0040;
    @(posedge clk); #1;
    chk("rst_flush", 32'(flush), 0);
    chk("rst_cancel", 32'(wb_cancel), 0);
    chk("rst_has_int", 32'(has_int), 0);
    foreach (rtab[i]) sbq.push_back(rtab[i]);
    drain();
    reset = 0; #1;
    chk("post_rst_flush", 32'(flush), 0);
    push(14'h06, 32'h0, "post_rst_era");
    push(14'h00, 32'h8, "post_rst_crmd");
    cyc();

    // Table of masked writes: no same-cycle bypass, then the new value.
    for (int i = 0; i < 16; i++) begin
      drive_wr(wtab[i].num, wtab[i].mask, wtab[i].wdata);
      #1;
      chk($sformatf("nobypass_%0d", i), csr_rvalue, wtab[i].old_v);
      push(wtab[i].num, wtab[i].new_v, $sformatf("wr_%0d", i));
      cyc();
    end

    // Syscall entry.
    wb_valid = 1; wb_syscall = 1; wb_pc = 32'h1C00_0100; wb_syscall_code = 15'h11;
    #1;
    chk("sys_flush", 32'(flush), 1);
    chk("sys_target", flush_target, 32'h1C00_8000);
    chk("sys_cancel", 32'(wb_cancel), 0);
    push(14'h06, 32'h1C00_0100, "sys_era");
    push(14'h05, 32'h000B_0000, "sys_estat");
    push(14'h01, 32'h7, "sys_prmd");
    push(14'h00, 32'h8, "sys_crmd");
    cyc();

    // Return.
    wb_valid = 1; wb_ertn = 1; wb_pc = 32'h1C00_8000;
    #1;
    chk("ertn_flush", 32'(flush), 1);
    chk("ertn_target", flush_target, 32'h1C00_0100);
    push(14'h00, 32'hF, "ertn_crmd");
    cyc();

    // One-shot timer.
    drive_wr(14'h41, 32'hFFFF_FFFF, 32'h0000_000D);
    push(14'h42, 32'hC, "tval_load");
    cyc();
    push(14'h42, 32'hB, "tval_dec");
    cyc();
    found = 0;
    csr_rnum = 14'h42;
    for (int i = 0; i < 40 && !found; i++) begin
      #1;
      if (csr_rvalue == 32'h0) found = 1;
      else cyc();
      csr_rnum = 14'h42;
    end
    chk("tval_reaches_0", 32'(found), 1);
    push(14'h42, 32'hFFFF_FFFF, "tval_wrap");
    push(14'h05, 32'h000B_0800, "timer_is11");
    cyc();
    push(14'h42, 32'hFFFF_FFFF, "tval_hold");
    cyc();

    drive_wr(14'h04, 32'hFFFF_FFFF, 32'h0000_0800);
    #1;
    chk("int_before_lie", 32'(has_int), 0);
    push(14'h04, 32'h800, "ecfg_lie11");
    cyc();
    #1;
    chk("has_int_set", 32'(has_int), 1);
    chk("no_flush_invalid", 32'(flush), 0);

    // Interrupt hits a WB instruction that carries a CSR write.
    drive_wr(14'h31, 32'hFFFF_FFFF, 32'hAAAA_AAAA);
    wb_pc = 32'h1C00_0200;
    #1;
    chk("int_cancel", 32'(wb_cancel), 1);
    chk("int_flush", 32'(flush), 1);
    chk("int_target", flush_target, 32'h1C00_8000);
    push(14'h31, 32'h0, "int_save1_kept");
    push(14'h05, 32'h0000_0800, "int_estat");
    push(14'h06, 32'h1C00_0200, "int_era");
    push(14'h00, 32'h8, "int_crmd");
    push(14'h01, 32'h7, "int_prmd");
    cyc();
    chk("int_ie_off", 32'(has_int), 0);

    drive_wr(14'h44, 32'hFFFF_FFFF, 32'h1);
    push(14'h05, 32'h0, "ticlr_estat");
    push(14'h44, 32'h0, "ticlr_read");
    cyc();
    drive_wr(14'h00, 32'h4, 32'h4);
    push(14'h00, 32'hC, "crmd_ie_on");
    cyc();
    #1;
    chk("cleared_no_int", 32'(has_int), 0);

    // Periodic timer; a TICLR in the firing cycle loses to the set.
    drive_wr(14'h41, 32'hFFFF_FFFF, 32'h0000_0007);
    push(14'h42, 32'h4, "per_load");
    cyc();
    for (int k = 3; k >= 0; k--) begin
      push(14'h42, 32'(k), $sformatf("per_cnt_%0d", k));
      cyc();
    end
    drive_wr(14'h44, 32'hFFFF_FFFF, 32'h1);
    #1;
    chk("per_pre_int", 32'(has_int), 0);
    push(14'h42, 32'h4, "per_reload");
    push(14'h05, 32'h0000_0800, "set_beats_clr");
    cyc();
    #1;
    chk("per_has_int", 32'(has_int), 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/csr_exc_unit.md
# csr_exc_unit

Control/status register file and exception/return controller at the end of the pipeline. It consumes the CSR-write, `ertn` and `syscall` information that MEM forwards to WB. It holds the LA32 privileged CSR subset plus the stable timer, and detects interrupts. On a valid exception, interrupt or `ertn` it updates the CSR state and issues the pipeline-wide flush with a redirect target.

## Interface
Parameters:
- `TIMER_W`, default 32: width of the timer counter (TVAL).

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `wb_valid` in 1: WB holds a valid instruction this cycle.
- `wb_pc` in 32: PC of the WB instruction.
- `csr_we` in 1: CSR write request from the WB instruction.
- `csr_num` in 14: CSR number for the write.
- `csr_wmask` in 32: per-bit write mask.
- `csr_wdata` in 32: write data.
- `csr_rnum` in 14: CSR number for the read port.
- `csr_rvalue` out 32: read data for `csr_rnum`, combinational.
- `wb_ertn` in 1: WB instruction is `ertn`.
- `wb_syscall` in 1: WB instruction is `syscall`.
- `wb_syscall_code` in 15: syscall code, informational only; not stored.
- `has_int` out 1: an interrupt is pending and enabled.
- `wb_cancel` out 1: the WB instruction is cancelled; the GPR write must be suppressed.
- `flush` out 1: pipeline flush this cycle.
- `flush_target` out 32: fetch redirect target, valid when `flush`=1.

## Operation
CSR map (unlisted numbers read as 0 and ignore writes):
- CRMD 0x0: PLV[1:0], IE[2], DA[3], PG[4]. Reset 0x0000_0008.
- PRMD 0x1: PPLV[1:0], PIE[2]. Reset 0.
- ECFG 0x4: LIE[12:0]; bit 10 is read-only 0. Reset 0.
- ESTAT 0x5: IS[12:0], Ecode[21:16], EsubCode[30:22]. Only IS[1:0] are software-writable. Reset 0.
- ERA 0x6: 32 bits. Reset 0.
- EENTRY 0xC: [31:6] writable, [5:0] read 0. Reset 0.
- SAVE0–3 0x30–0x33: 32 bits each. Reset 0.
- TID 0x40: 32 bits. Reset 0.
- TCFG 0x41: En[0], Periodic[1], InitVal[31:2]. Reset 0.
- TVAL 0x42: read-only timer count. Reset 0xFFFF_FFFF.
- TICLR 0x44: writing 1 to bit 0 clears IS[11]. Reads 0.

Write rule:
- Effective write when `wb_valid & csr_we & ~wb_cancel`.
- new = (old & ~mask) | (wdata & mask), then restricted to the writable bits above.

Timer:
- On an effective TCFG write with new En=1, TVAL loads {InitVal, 2'b00}.
- Otherwise, when En=1 and TVAL≠0xFFFF_FFFF, TVAL decrements each cycle.
- When En=1 and TVAL==0:
  - IS[11] is set.
  - If Periodic=1, TVAL reloads {InitVal, 2'b00}.
  - If Periodic=0, TVAL wraps to 0xFFFF_FFFF and holds.

Interrupt detection:
- `has_int` = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]).

Events (only when `wb_valid`=1), in priority order:
1. Interrupt: `has_int`=1. Ecode=0x0, EsubCode=0.
2. Syscall: `wb_syscall`=1. Ecode=0xB, EsubCode=0.
3. Ertn: `wb_ertn`=1.

Exception entry (interrupt or syscall):
- PRMD.PPLV←CRMD.PLV, PRMD.PIE←CRMD.IE.
- CRMD.PLV←0, CRMD.IE←0.
- ERA←`wb_pc`; ESTAT.Ecode and ESTAT.EsubCode are set per the event.
- `flush`=1, `flush_target`=EENTRY.
- `wb_cancel`=1 for interrupts only; the syscall itself writes no GPR.

Ertn:
- CRMD.PLV←PRMD.PPLV, CRMD.IE←PRMD.PIE.
- `flush`=1, `flush_target`=ERA.

## Timing
- `csr_rvalue`, `has_int`, `wb_cancel`, `flush` and `flush_target` are combinational from current state and inputs. All state updates occur at the next rising edge.
- The read port has no write bypass: reading a CSR in the same cycle it is written returns the old value.
- `flush_target` uses pre-update EENTRY/ERA. A same-cycle CSR write never affects the target, because an event cancels or excludes that write.
- While `reset`=1, all registers take their reset values. In that cycle and the one after, `flush`, `wb_cancel` and `has_int` are 0, regardless of inputs.
- Timer set of IS[11] and a TICLR clear in the same cycle: the set wins.
- A software write to ESTAT never alters IS[12:2].
- Interrupt coinciding with syscall/ertn: the interrupt wins; ERA←`wb_pc`, so the instruction re-executes after return.
- Events and writes are ignored when `wb_valid`=0. The timer runs regardless of `wb_valid`.

## Test plan
- Reset → CRMD=0x8, TVAL=0xFFFF_FFFF, every other CSR 0; `flush`=0; `has_int`=0.
- Write EENTRY=0x1C00_8000 and CRMD: wdata 0x7, mask 0x7 (CRMD becomes 0xF). Then syscall at `wb_pc`=0x1C00_0100 → `flush`=1, target 0x1C00_8000. Next cycle: ERA=0x1C00_0100, ESTAT.Ecode=0xB, PRMD=0x7, CRMD=0x8.
- Following `ertn` → `flush`=1, target 0x1C00_0100. Next cycle CRMD=0xF.
- With SAVE0=0xFFFF_0000, write wdata 0x1234_5678, mask 0x0000_FFFF → SAVE0=0xFFFF_5678. A read of SAVE0 in the write cycle returns 0xFFFF_0000.
- TCFG=0x0000_000D → TVAL=0xC, then counts down. At TVAL=0, IS[11]=1; TVAL then holds 0xFFFF_FFFF. With ECFG=0x800 and CRMD.IE=1, `has_int`=1. TICLR wdata 1 → IS[11]=0 and `has_int`=0.
- Pending interrupt while WB carries a valid SAVE1 write of 0xAAAA_AAAA at `wb_pc`=0x1C00_0200 → `wb_cancel`=1, `flush`=1. SAVE1 is unchanged, Ecode=0, ERA=0x1C00_0200, CRMD.IE=0.
